// File: rtl/pru_cmd_sequencer.sv
// pru_cmd_sequencer: MMIO-fed draw-command queue that issues commands to the
// pixel rendering unit over a start/busy/done four-phase handshake.
//
// PRU handshake: pru_start is raised once the command parameters are stable
// and held until pru_done is seen (or the wait times out). The PRU keeps
// pru_done high until pru_start drops. The next command is not issued until
// both pru_done and pru_busy read low. The pru_* parameter outputs change only
// when a command is popped, so they are stable for the whole handshake.
// MMIO: mmio_we/mmio_re are single-cycle strobes with no back-pressure. Every
// read strobe yields exactly one mmio_rvalid pulse on the following cycle.
module pru_cmd_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    output logic        mmio_rvalid,
    output logic        pru_start,
    output logic [1:0]  pru_shape_select,
    output logic [1:0]  pru_color,
    output logic [9:0]  pru_col,
    output logic [8:0]  pru_row,
    output logic [9:0]  pru_width,
    output logic [8:0]  pru_height_radius,
    input  logic        pru_busy,
    input  logic        pru_done,
    output logic        seq_idle,
    output logic [1:0]  dbg_state
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [31:0] ADDR_GEOM = 32'h0000_4010;
    localparam logic [31:0] ADDR_SIZE = 32'h0000_4014;
    localparam logic [31:0] ADDR_STAT = 32'h0000_4018;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RELEASE   = 2'd3
    } state_t;

    state_t state, state_d;

    // Queue entry layout: {shape, color, row, col, height_radius, width}
    logic [22:0] geom_q;
    logic [41:0] fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [TW-1:0] to_cnt;
    logic [15:0]   done_cnt;
    logic          overflow_q, timeout_q;

    logic wr_geom, wr_size, wr_stat, rd_stat;
    logic fifo_empty, fifo_full, pop, push_ok, overflow_set;
    logic to_hit, done_evt, timeout_evt;
    logic [3:0]  count4;
    logic [31:0] stat_word;
    logic        unused_wdata;

    assign wr_geom = mmio_we && (mmio_addr == ADDR_GEOM);
    assign wr_size = mmio_we && (mmio_addr == ADDR_SIZE);
    assign wr_stat = mmio_we && (mmio_addr == ADDR_STAT);
    assign rd_stat = mmio_re && (mmio_addr == ADDR_STAT);
    assign unused_wdata = ^mmio_wdata[31:23];

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == CW'(CMD_DEPTH));
    assign pop          = (state == S_IDLE) && !fifo_empty;
    // A commit to a full queue still lands if the head leaves in the same cycle.
    assign push_ok      = wr_size && (!fifo_full || pop);
    assign overflow_set = wr_size && fifo_full && !pop;

    assign to_hit      = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign done_evt    = (state == S_WAIT_DONE) && pru_done;
    assign timeout_evt = (state == S_WAIT_DONE) && !pru_done && to_hit;

    assign seq_idle  = fifo_empty && (state == S_IDLE);
    assign dbg_state = state;

    // Count field is 4 bits wide; a 16-deep queue reads 0 when full (full bit is set).
    assign count4    = 4'(fifo_count);
    assign stat_word = {done_cnt, 8'h00, count4, timeout_q, overflow_q, fifo_full, !seq_idle};

    // Next-state logic for the issue handshake.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:      if (!fifo_empty) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (pru_done || to_hit) state_d = S_RELEASE;
            S_RELEASE:   if (!pru_done && !pru_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register, registered pru_start and the WAIT_DONE timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pru_start <= 1'b0;
            to_cnt    <= '0;
        end else begin
            state     <= state_d;
            pru_start <= (state_d == S_WAIT_DONE);
            to_cnt    <= (state == S_WAIT_DONE) ? to_cnt + 1'b1 : '0;
        end
    end

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= {geom_q, mmio_wdata[18:0]};
    end

    // Queue pointers/occupancy and GEOM staging register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            geom_q     <= '0;
        end else begin
            if (wr_geom) geom_q <= mmio_wdata[22:0];
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Command parameters to the PRU: loaded only when the head is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pru_shape_select  <= '0;
            pru_color         <= '0;
            pru_row           <= '0;
            pru_col           <= '0;
            pru_height_radius <= '0;
            pru_width         <= '0;
        end else if (pop) begin
            {pru_shape_select, pru_color, pru_row, pru_col,
             pru_height_radius, pru_width} <= fifo_mem[rd_ptr];
        end
    end

    // Sticky error bits (a same-cycle set beats a W1C clear) and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (overflow_set)                      overflow_q <= 1'b1;
            else if (wr_stat && mmio_wdata[2])     overflow_q <= 1'b0;
            if (timeout_evt)                       timeout_q  <= 1'b1;
            else if (wr_stat && mmio_wdata[3])     timeout_q  <= 1'b0;
            if (done_evt)                          done_cnt   <= done_cnt + 1'b1;
        end
    end

    // Registered read port: STAT reflects the values before this cycle's updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_rvalid <= 1'b0;
            mmio_rdata  <= '0;
        end else begin
            mmio_rvalid <= mmio_re;
            mmio_rdata  <= rd_stat ? stat_word : 32'h0;
        end
    end

endmodule
